// File: rtl/regfile_sched_pkg.sv
// regfile_sched_pkg: shared widths, write record, clear FSM state and clear-range helper
// for the regfile write-port scheduler.
package regfile_sched_pkg;
    localparam int RF_ADDR_W = 10;
    localparam int RF_HART_W = 5;
    localparam int RF_REG_W  = 5;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_t;

    // True when address a lies in bank h at or above the next register the clear will zero.
    function automatic logic clr_pending(input logic [RF_ADDR_W-1:0] a,
                                         input logic [RF_HART_W-1:0] h,
                                         input logic [RF_REG_W-1:0]  c);
        return a[RF_ADDR_W-1:RF_REG_W] == h && a[RF_REG_W-1:0] >= c;
    endfunction
endpackage

// File: rtl/regfile_sched_wb_fifo.sv
// wb_fifo: load-writeback buffer of rf_wr_t records.
// Ports: clock, reset (sync, active-high); push/wr enqueue; pop/head dequeue;
// full/empty status; ent_valid/ent_addr expose every slot for pending-write checks.
module wb_fifo
    import regfile_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  push,
    input  logic                                  pop,
    input  rf_wr_t                                wr,
    output rf_wr_t                                head,
    output logic                                  full,
    output logic                                  empty,
    output logic [FIFO_DEPTH-1:0]                 ent_valid,
    output logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0]  ent_addr
);
    localparam int PW = $clog2(FIFO_DEPTH);

    rf_wr_t     mem [FIFO_DEPTH];
    logic [PW:0] wp, rp, cnt;

    assign cnt   = wp - rp;
    assign full  = cnt == (PW+1)'(FIFO_DEPTH);
    assign empty = wp == rp;
    assign head  = mem[rp[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= push ? wp + 1'b1 : wp;
            rp <= pop ? rp + 1'b1 : rp;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wp[PW-1:0]] <= wr;
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_addr[i]  = mem[i].addr;
            ent_valid[i] = {1'b0, PW'(i) - rp[PW-1:0]} < cnt;
        end
    end
endmodule

// File: rtl/regfile_sched.sv
// regfile_sched: shares the regfile write port between ALU writeback, buffered load
// writeback and a per-hart bank clear, and flags reads of still-pending writes.
// Ports: clock, reset (sync, active-high); alu_wr_*; mem_wr_* with mem_wr_ready;
// clr_req/clr_hart with clr_busy/clr_done; chk_addr1/2 -> chk_hit; rf_waddr/rf_wdata/rf_wren.
// Option: define REGFILE_SCHED_X0_FILTER_EN to drop ALU/load writes to register 0.
module regfile_sched
    import regfile_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_wr_valid,
    input  logic [RF_ADDR_W-1:0] alu_wr_addr,
    input  logic [RF_DATA_W-1:0] alu_wr_data,
    input  logic                 mem_wr_valid,
    input  logic [RF_ADDR_W-1:0] mem_wr_addr,
    input  logic [RF_DATA_W-1:0] mem_wr_data,
    output logic                 mem_wr_ready,
    input  logic                 clr_req,
    input  logic [RF_HART_W-1:0] clr_hart,
    output logic                 clr_busy,
    output logic                 clr_done,
    input  logic [RF_ADDR_W-1:0] chk_addr1,
    input  logic [RF_ADDR_W-1:0] chk_addr2,
    output logic                 chk_hit,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [RF_DATA_W-1:0] rf_wdata,
    output logic                 rf_wren
);
    clr_state_t                           state;
    logic [RF_HART_W-1:0]                 hart;
    logic [RF_REG_W-1:0]                  cnt;
    rf_wr_t                               head;
    logic                                 full, empty, fifo_hit;
    logic [FIFO_DEPTH-1:0]                ent_valid;
    logic [FIFO_DEPTH-1:0][RF_ADDR_W-1:0] ent_addr;
    logic alu_x0, mem_x0, alu_use, mem_acc, mem_keep, pop, bypass, push, clr_wr;

`ifdef REGFILE_SCHED_X0_FILTER_EN
    assign alu_x0 = alu_wr_addr[RF_REG_W-1:0] == '0;
    assign mem_x0 = mem_wr_addr[RF_REG_W-1:0] == '0;
`else
    assign alu_x0 = 1'b0;
    assign mem_x0 = 1'b0;
`endif

    // Everything is gated by reset so the port and status outputs read idle while it is held.
    assign mem_wr_ready = !reset && !full;
    assign alu_use      = !reset && alu_wr_valid && !alu_x0;
    assign mem_acc      = mem_wr_valid && mem_wr_ready;
    assign mem_keep     = mem_acc && !mem_x0;
    assign pop          = !reset && !empty && !alu_use;
    assign bypass       = mem_keep && empty && !alu_use;
    assign push         = mem_keep && !bypass;
    assign clr_wr       = !reset && state == CLR_RUN && !alu_use && !pop && !bypass;

    assign rf_wren  = alu_use || pop || bypass || clr_wr;
    assign rf_waddr = alu_use ? alu_wr_addr : pop ? head.addr : bypass ? mem_wr_addr :
                      clr_wr ? {hart, cnt} : '0;
    assign rf_wdata = alu_use ? alu_wr_data : pop ? head.data : bypass ? mem_wr_data : '0;

    assign clr_busy = !reset && state != CLR_IDLE;
    assign clr_done = !reset && state == CLR_DONE;

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr        ('{addr: mem_wr_addr, data: mem_wr_data}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_hit |= ent_valid[i] && (ent_addr[i] == chk_addr1 || ent_addr[i] == chk_addr2);
    end

    assign chk_hit = !reset && (fifo_hit || (state == CLR_RUN &&
                     (clr_pending(chk_addr1, hart, cnt) || clr_pending(chk_addr2, hart, cnt))));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLR_IDLE;
            hart  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                CLR_IDLE: if (clr_req) begin
                    hart  <= clr_hart;
                    cnt   <= '0;
                    state <= CLR_RUN;
                end
                CLR_RUN: if (clr_wr) begin
                    cnt   <= cnt + 1'b1;
                    state <= &cnt ? CLR_DONE : CLR_RUN;
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sched.sv
// tb_regfile_sched: directed self-checking bench for regfile_sched.
module tb_regfile_sched;
    logic        clock = 1'b0;
    logic        reset;
    logic        alu_wr_valid, mem_wr_valid, mem_wr_ready, clr_req, clr_busy, clr_done;
    logic [9:0]  alu_wr_addr, mem_wr_addr, chk_addr1, chk_addr2, rf_waddr;
    logic [31:0] alu_wr_data, mem_wr_data, rf_wdata;
    logic [4:0]  clr_hart;
    logic        chk_hit, rf_wren;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    regfile_sched dut (
        .clock        (clock),
        .reset        (reset),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_ready (mem_wr_ready),
        .clr_req      (clr_req),
        .clr_hart     (clr_hart),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .chk_addr1    (chk_addr1),
        .chk_addr2    (chk_addr2),
        .chk_hit      (chk_hit),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_wren      (rf_wren)
    );

    task automatic idle_inputs();
        alu_wr_valid = 0; alu_wr_addr = '0; alu_wr_data = '0;
        mem_wr_valid = 0; mem_wr_addr = '0; mem_wr_data = '0;
        clr_req = 0; clr_hart = '0;
        chk_addr1 = 10'h3FF; chk_addr2 = 10'h3FE;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        alu_wr_valid = 1; alu_wr_addr = 10'h021; alu_wr_data = 32'h1;
        mem_wr_valid = 1; mem_wr_addr = 10'h041;
        clr_req = 1; clr_hart = 5'd3; chk_addr1 = 10'h041;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %0h want 0", rf_wren); end
        checks++; if (mem_wr_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0h want 0", mem_wr_ready); end
        checks++; if (rf_waddr !== 10'h0 || rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_wbus: got %h/%h want 0/0", rf_waddr, rf_wdata); end
        checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin failures++; $display("FAIL reset_clr: got busy=%0h done=%0h want 0/0", clr_busy, clr_done); end
        checks++; if (chk_hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %0h want 0", chk_hit); end
        @(negedge clock);
        reset = 0;
        idle_inputs();
        #1;
        checks++; if (mem_wr_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %0h want 1", mem_wr_ready); end
        checks++; if (rf_wren !== 1'b0 || clr_busy !== 1'b0 || chk_hit !== 1'b0) begin failures++; $display("FAIL post_reset_idle: got wren=%0h busy=%0h hit=%0h want 0/0/0", rf_wren, clr_busy, chk_hit); end
    endtask

    task automatic test_alu();
        @(negedge clock);
        alu_wr_valid = 1; alu_wr_addr = 10'h021; alu_wr_data = 32'hDEADBEEF;
        #1;
        checks++; if (rf_wren !== 1'b1 || rf_waddr !== 10'h021 || rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_write: got %0h/%h/%h want 1/021/deadbeef", rf_wren, rf_waddr, rf_wdata); end
        checks++; if (mem_wr_ready !== 1'b1) begin failures++; $display("FAIL alu_ready: got %0h want 1", mem_wr_ready); end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL alu_idle: got %0h want 0", rf_wren); end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_wr_valid = 1; mem_wr_addr = 10'h101 + 10'(i); mem_wr_data = 32'hB0 + 32'(i);
            chk_addr1 = mem_wr_addr;
            #1;
            checks++; if (rf_wren !== 1'b1 || rf_waddr !== 10'h101 + 10'(i) || rf_wdata !== 32'hB0 + 32'(i)) begin failures++; $display("FAIL bypass_%0d: got %0h/%h/%h want 1/%h/%h", i, rf_wren, rf_waddr, rf_wdata, 10'h101 + 10'(i), 32'hB0 + 32'(i)); end
            checks++; if (mem_wr_ready !== 1'b1 || chk_hit !== 1'b0) begin failures++; $display("FAIL bypass_flags_%0d: got ready=%0h hit=%0h want 1/0", i, mem_wr_ready, chk_hit); end
        end
        @(negedge clock);
        idle_inputs();
        #1;
        checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL bypass_drain: got %0h want 0", rf_wren); end
    endtask

    // ALU busy on cycles 0-2, loads 0x041..0x043 offered from cycle 0; loads land on cycles 3-5.
    task automatic test_contention();
        logic [9:0]  ea;
        logic [31:0] ed;
        logic        er, eh, ew;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            alu_wr_valid = c < 3; alu_wr_addr = 10'h100 + 10'(c); alu_wr_data = 32'h5000_0000 + 32'(c);
            mem_wr_valid = c <= 4;
            mem_wr_addr  = c == 0 ? 10'h041 : c == 1 ? 10'h042 : 10'h043;
            mem_wr_data  = 32'hA000_0000 | 32'(mem_wr_addr);
            chk_addr1 = 10'h042; chk_addr2 = 10'h3FE;
            ew = c < 6;
            ea = c < 3 ? 10'h100 + 10'(c) : c == 3 ? 10'h041 : c == 4 ? 10'h042 : c == 5 ? 10'h043 : 10'h0;
            ed = c < 3 ? 32'h5000_0000 + 32'(c) : c < 6 ? 32'hA000_0000 | 32'(ea) : 32'h0;
            er = !(c == 2 || c == 3);
            eh = c >= 2 && c <= 4;
            #1;
            checks++; if (rf_wren !== ew || rf_waddr !== ea || rf_wdata !== ed) begin failures++; $display("FAIL contention_port_c%0d: got %0h/%h/%h want %0h/%h/%h", c, rf_wren, rf_waddr, rf_wdata, ew, ea, ed); end
            checks++; if (mem_wr_ready !== er) begin failures++; $display("FAIL contention_ready_c%0d: got %0h want %0h", c, mem_wr_ready, er); end
            checks++; if (chk_hit !== eh) begin failures++; $display("FAIL contention_hit_c%0d: got %0h want %0h", c, chk_hit, eh); end
        end
        idle_inputs();
    endtask

    // clr_req in cycle 0, zero writes in cycles 1-32, clr_done in cycle 33 (34th cycle counting the request).
    task automatic test_clear_idle();
        @(negedge clock);
        clr_req = 1; clr_hart = 5'd3; chk_addr1 = 10'h070; chk_addr2 = 10'h3FE;
        #1;
        checks++; if (clr_busy !== 1'b0 || rf_wren !== 1'b0) begin failures++; $display("FAIL clear_req_cycle: got busy=%0h wren=%0h want 0/0", clr_busy, rf_wren); end
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            clr_req = k == 5; clr_hart = 5'd9;
            #1;
            checks++; if (rf_wren !== 1'b1 || rf_waddr !== 10'h060 + 10'(k) || rf_wdata !== 32'h0) begin failures++; $display("FAIL clear_write_%0d: got %0h/%h/%h want 1/%h/0", k, rf_wren, rf_waddr, rf_wdata, 10'h060 + 10'(k)); end
            checks++; if (clr_busy !== 1'b1 || clr_done !== 1'b0 || chk_hit !== (k <= 16)) begin failures++; $display("FAIL clear_status_%0d: got busy=%0h done=%0h hit=%0h want 1/0/%0h", k, clr_busy, clr_done, chk_hit, k <= 16); end
        end
        @(negedge clock);
        clr_req = 0;
        #1;
        checks++; if (clr_done !== 1'b1 || rf_wren !== 1'b0 || chk_hit !== 1'b0) begin failures++; $display("FAIL clear_done: got done=%0h wren=%0h hit=%0h want 1/0/0", clr_done, rf_wren, chk_hit); end
        @(negedge clock);
        #1;
        checks++; if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin failures++; $display("FAIL clear_after_done: got done=%0h busy=%0h want 0/0", clr_done, clr_busy); end
        idle_inputs();
    endtask

    // ALU hits 0x065 when cnt=5; the zero follows one cycle later and clr_done slips to cycle 34.
    task automatic test_clear_interrupted();
        logic [9:0]  ea;
        logic [31:0] ed;
        @(negedge clock);
        clr_req = 1; clr_hart = 5'd3; chk_addr2 = 10'h07F;
        for (int w = 1; w <= 33; w++) begin
            @(negedge clock);
            clr_req = 0;
            alu_wr_valid = w == 6; alu_wr_addr = 10'h065; alu_wr_data = 32'h12345678;
            ea = w <= 5 ? 10'h060 + 10'(w - 1) : w == 6 ? 10'h065 : 10'h060 + 10'(w - 2);
            ed = w == 6 ? 32'h12345678 : 32'h0;
            #1;
            checks++; if (rf_wren !== 1'b1 || rf_waddr !== ea || rf_wdata !== ed) begin failures++; $display("FAIL intr_write_w%0d: got %0h/%h/%h want 1/%h/%h", w, rf_wren, rf_waddr, rf_wdata, ea, ed); end
            checks++; if (chk_hit !== 1'b1 || clr_done !== 1'b0) begin failures++; $display("FAIL intr_status_w%0d: got hit=%0h done=%0h want 1/0", w, chk_hit, clr_done); end
        end
        @(negedge clock);
        alu_wr_valid = 0;
        #1;
        checks++; if (clr_done !== 1'b1 || rf_wren !== 1'b0) begin failures++; $display("FAIL intr_done: got done=%0h wren=%0h want 1/0", clr_done, rf_wren); end
        @(negedge clock);
        #1;
        checks++; if (clr_done !== 1'b0) begin failures++; $display("FAIL intr_after_done: got %0h want 0", clr_done); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        int done_seen = 0;
        int wren_seen = 0;
        @(negedge clock);
        clr_req = 1; clr_hart = 5'd3;
        for (int w = 1; w <= 10; w++) begin
            @(negedge clock);
            clr_req = 0;
        end
        @(negedge clock);
        alu_wr_valid = 1; alu_wr_addr = 10'h200; alu_wr_data = 32'hCAFE;
        mem_wr_valid = 1; mem_wr_addr = 10'h0C1; mem_wr_data = 32'hBEEF;
        #1;
        checks++; if (rf_waddr !== 10'h200 || mem_wr_ready !== 1'b1) begin failures++; $display("FAIL mid_alu: got addr=%h ready=%0h want 200/1", rf_waddr, mem_wr_ready); end
        @(negedge clock);
        idle_inputs();
        chk_addr1 = 10'h0C1; chk_addr2 = 10'h06A;
        #1;
        checks++; if (chk_hit !== 1'b1 || rf_waddr !== 10'h0C1) begin failures++; $display("FAIL mid_queued: got hit=%0h addr=%h want 1/0c1", chk_hit, rf_waddr); end
        chk_addr1 = 10'h3FF;
        #1;
        checks++; if (chk_hit !== 1'b1) begin failures++; $display("FAIL mid_cnt10_hit: got %0h want 1", chk_hit); end
        chk_addr1 = 10'h0C1;
        reset = 1;
        #1;
        checks++; if (rf_wren !== 1'b0 || mem_wr_ready !== 1'b0 || chk_hit !== 1'b0) begin failures++; $display("FAIL mid_in_reset: got wren=%0h ready=%0h hit=%0h want 0/0/0", rf_wren, mem_wr_ready, chk_hit); end
        @(negedge clock);
        reset = 0;
        #1;
        checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0 || rf_wren !== 1'b0) begin failures++; $display("FAIL mid_after_reset: got busy=%0h done=%0h wren=%0h want 0/0/0", clr_busy, clr_done, rf_wren); end
        checks++; if (chk_hit !== 1'b0 || mem_wr_ready !== 1'b1) begin failures++; $display("FAIL mid_fifo_empty: got hit=%0h ready=%0h want 0/1", chk_hit, mem_wr_ready); end
        for (int w = 0; w < 40; w++) begin
            @(negedge clock);
            #1;
            done_seen += int'(clr_done);
            wren_seen += int'(rf_wren);
        end
        checks++; if (done_seen != 0 || wren_seen != 0) begin failures++; $display("FAIL mid_quiet: got done=%0d wren=%0d cycles want 0/0", done_seen, wren_seen); end
        idle_inputs();
    endtask

    task automatic test_x0();
        @(negedge clock);
        alu_wr_valid = 1; alu_wr_addr = 10'h040; alu_wr_data = 32'h1;
        mem_wr_valid = 1; mem_wr_addr = 10'h020; mem_wr_data = 32'h2;
        chk_addr1 = 10'h020;
        #1;
`ifdef REGFILE_SCHED_X0_FILTER_EN
        checks++; if (rf_wren !== 1'b0 || mem_wr_ready !== 1'b1) begin failures++; $display("FAIL x0_drop: got wren=%0h ready=%0h want 0/1", rf_wren, mem_wr_ready); end
        @(negedge clock);
        idle_inputs();
        chk_addr1 = 10'h020;
        #1;
        checks++; if (rf_wren !== 1'b0 || chk_hit !== 1'b0) begin failures++; $display("FAIL x0_never: got wren=%0h hit=%0h want 0/0", rf_wren, chk_hit); end
`else
        checks++; if (rf_wren !== 1'b1 || rf_waddr !== 10'h040 || mem_wr_ready !== 1'b1) begin failures++; $display("FAIL x0_pass_alu: got %0h/%h ready=%0h want 1/040/1", rf_wren, rf_waddr, mem_wr_ready); end
        @(negedge clock);
        idle_inputs();
        chk_addr1 = 10'h020;
        #1;
        checks++; if (rf_wren !== 1'b1 || rf_waddr !== 10'h020 || rf_wdata !== 32'h2 || chk_hit !== 1'b1) begin failures++; $display("FAIL x0_pass_load: got %0h/%h/%h hit=%0h want 1/020/2/1", rf_wren, rf_waddr, rf_wdata, chk_hit); end
`endif
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_bypass();
        test_contention();
        test_clear_idle();
        test_clear_interrupted();
        test_reset_mid_clear();
        test_x0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
